// File: rtl/ahb_lite_master_driver_if.sv
// Signal bundle for ahb_lite_master_driver: command push, completion report
// and the AHB-Lite master bus. The driver uses the master modport.
interface ahb_lite_master_driver_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  // Command push
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [2:0]        cmd_size;

  // Completion report
  logic              rsp_valid;
  logic              rsp_write;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;

  // AHB-Lite master side
  logic [ADDR_W-1:0] HADDR;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [3:0]        HPROT;
  logic [1:0]        HTRANS;
  logic              HMASTLOCK;
  logic [DATA_W-1:0] HWDATA;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADY;
  logic              HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_size,
    output cmd_ready,
    output rsp_valid, rsp_write, rsp_err, rsp_rdata,
    output HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_size,
    input  cmd_ready,
    input  rsp_valid, rsp_write, rsp_err, rsp_rdata,
    input  HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
    output HRDATA, HREADY, HRESP
  );

endinterface

// File: rtl/ahb_lite_master_driver.sv
// AHB-Lite master driver: queues commands in a FIFO and issues them in order
// as pipelined SINGLE transfers, reporting one completion per command.
module ahb_lite_master_driver #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CMD_DEPTH = 4
) (
  input logic                      HCLK,
  input logic                      HRESETn,
  ahb_lite_master_driver_if.master bus
);

  localparam int unsigned PtrW    = $clog2(CMD_DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned MaxSize = $clog2(DATA_W / 8);

  localparam logic [2:0] MaxSizeEnc = 3'(MaxSize);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StAddr     = 3'd1;
  localparam logic [2:0] StAddrData = 3'd2;
  localparam logic [2:0] StData     = 3'd3;
  localparam logic [2:0] StErr      = 3'd4;

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;

  // Command FIFO storage; only pointers and count need reset
  logic              fifo_write_q [CMD_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_q  [CMD_DEPTH];
  logic [DATA_W-1:0] fifo_wdata_q [CMD_DEPTH];
  logic [2:0]        fifo_size_q  [CMD_DEPTH];

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            fifo_full;
  logic            push, pop;

  logic              head_write;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;
  logic [2:0]        head_size;
  logic [ADDR_W-1:0] align_mask;
  logic              head_ok;

  logic [2:0] state_q, state_d;
  logic       in_addr, in_data, in_err;
  logic       err_now, nonseq, addr_accept, bad_pop, data_done;
  logic       data_next, err_next;

  // Address outputs hold their last driven value while no transfer is offered
  logic [ADDR_W-1:0] haddr_q;
  logic              hwrite_q;
  logic [2:0]        hsize_q;
  logic [DATA_W-1:0] hwdata_q;
  logic              dp_write_q;

  logic              rsp_valid_q;
  logic              rsp_write_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  // FIFO head and command legality
  assign head_write = fifo_write_q[rd_ptr_q];
  assign head_addr  = fifo_addr_q[rd_ptr_q];
  assign head_wdata = fifo_wdata_q[rd_ptr_q];
  assign head_size  = fifo_size_q[rd_ptr_q];

  assign align_mask = ~({ADDR_W{1'b1}} << head_size);
  assign head_ok    = (head_size <= MaxSizeEnc) && ((head_addr & align_mask) == '0);

  assign fifo_full     = (count_q == CntW'(CMD_DEPTH));
  assign push          = bus.cmd_valid && !fifo_full;
  assign bus.cmd_ready = !fifo_full;

  // Transfer control
  assign in_addr = (state_q == StAddr) || (state_q == StAddrData);
  assign in_data = (state_q == StAddrData) || (state_q == StData);
  assign in_err  = (state_q == StErr);

  // First cycle of a two-cycle ERROR response: withdraw the pending address
  assign err_now     = in_data && bus.HRESP && !bus.HREADY;
  assign nonseq      = in_addr && head_ok && !err_now;
  assign addr_accept = nonseq && bus.HREADY;

  // An illegal head is retired without a bus transfer, but only once no data
  // phase is outstanding so its error response stays in order.
  assign bad_pop   = (state_q == StAddr) && !head_ok;
  assign data_done = (in_data || in_err) && bus.HREADY;
  assign pop       = addr_accept || bad_pop;

  always_comb begin
    count_d   = count_q + CntW'(push) - CntW'(pop);
    data_next = 1'b0;
    err_next  = 1'b0;

    if (in_err) begin
      err_next = !bus.HREADY;
    end else if (in_data && !bus.HREADY) begin
      err_next  = err_now;
      data_next = !err_now;
    end else begin
      data_next = addr_accept;
    end

    if (err_next) begin
      state_d = StErr;
    end else if (data_next) begin
      state_d = (count_d != '0) ? StAddrData : StData;
    end else begin
      state_d = (count_d != '0) ? StAddr : StIdle;
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) begin
      fifo_write_q[wr_ptr_q] <= bus.cmd_write;
      fifo_addr_q[wr_ptr_q]  <= bus.cmd_addr;
      fifo_wdata_q[wr_ptr_q] <= bus.cmd_wdata;
      fifo_size_q[wr_ptr_q]  <= bus.cmd_size;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= StIdle;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'b000;
      hwdata_q    <= '0;
      dp_write_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end

      if (nonseq) begin
        haddr_q  <= head_addr;
        hwrite_q <= head_write;
        hsize_q  <= head_size;
      end

      // Reads leave HWDATA at its previous value
      if (addr_accept) begin
        dp_write_q <= head_write;
        if (head_write) begin
          hwdata_q <= head_wdata;
        end
      end

      rsp_valid_q <= data_done || bad_pop;
      if (data_done) begin
        rsp_write_q <= dp_write_q;
        rsp_err_q   <= bus.HRESP || in_err;
        rsp_rdata_q <= dp_write_q ? '0 : bus.HRDATA;
      end else if (bad_pop) begin
        rsp_write_q <= head_write;
        rsp_err_q   <= 1'b1;
        rsp_rdata_q <= '0;
      end
    end
  end

  assign bus.HTRANS    = nonseq ? TransNonseq : TransIdle;
  assign bus.HADDR     = nonseq ? head_addr : haddr_q;
  assign bus.HWRITE    = nonseq ? head_write : hwrite_q;
  assign bus.HSIZE     = nonseq ? head_size : hsize_q;
  assign bus.HBURST    = 3'b000;
  assign bus.HPROT     = 4'b0011;
  assign bus.HMASTLOCK = 1'b0;
  assign bus.HWDATA    = hwdata_q;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahb_lite_master_driver.sv
// Self-checking bench for ahb_lite_master_driver: per-cycle vector table plus
// hand-written FIFO-full and mid-transfer reset sequences.
module tb_ahb_lite_master_driver;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ahb_lite_master_driver_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ahb_lite_master_driver #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .CMD_DEPTH(4)
  ) dut (
    .HCLK   (clk),
    .HRESETn(rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic        cv;
    logic        cw;
    logic [31:0] caddr;
    logic [31:0] cwdata;
    logic [2:0]  csize;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;
    logic        e_ready;
    logic [1:0]  e_htrans;
    logic [31:0] e_haddr;
    logic        e_hwrite;
    logic [2:0]  e_hsize;
    logic [31:0] e_hwdata;
    logic        e_rv;
    logic        e_rw;
    logic        e_re;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[$];
  vec_t cur;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, want);
    end
  endtask

  task automatic vin(input int cv, input int cw, input int a, input int wd, input int sz,
                     input int rdy, input int rsp, input int rd);
    cur.cv     = cv[0];
    cur.cw     = cw[0];
    cur.caddr  = a;
    cur.cwdata = wd;
    cur.csize  = sz[2:0];
    cur.hready = rdy[0];
    cur.hresp  = rsp[0];
    cur.hrdata = rd;
  endtask

  task automatic nop(input int rd);
    vin(0, 0, 0, 0, 0, 1, 0, rd);
  endtask

  task automatic vout(input int rdy, input int tr, input int a, input int wr, input int sz,
                      input int wd, input int rv, input int rw, input int re, input int rd);
    cur.e_ready  = rdy[0];
    cur.e_htrans = tr[1:0];
    cur.e_haddr  = a;
    cur.e_hwrite = wr[0];
    cur.e_hsize  = sz[2:0];
    cur.e_hwdata = wd;
    cur.e_rv     = rv[0];
    cur.e_rw     = rw[0];
    cur.e_re     = re[0];
    cur.e_rdata  = rd;
    vecs.push_back(cur);
  endtask

  task automatic check_reset(input int tag);
    check("rst_HTRANS", tag, 32'(bus.HTRANS), 32'd0);
    check("rst_HADDR", tag, bus.HADDR, 32'd0);
    check("rst_HWRITE", tag, 32'(bus.HWRITE), 32'd0);
    check("rst_HSIZE", tag, 32'(bus.HSIZE), 32'd0);
    check("rst_HBURST", tag, 32'(bus.HBURST), 32'd0);
    check("rst_HPROT", tag, 32'(bus.HPROT), 32'd3);
    check("rst_HMASTLOCK", tag, 32'(bus.HMASTLOCK), 32'd0);
    check("rst_HWDATA", tag, bus.HWDATA, 32'd0);
    check("rst_cmd_ready", tag, 32'(bus.cmd_ready), 32'd1);
    check("rst_rsp_valid", tag, 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_err", tag, 32'(bus.rsp_err), 32'd0);
    check("rst_rsp_write", tag, 32'(bus.rsp_write), 32'd0);
    check("rst_rsp_rdata", tag, bus.rsp_rdata, 32'd0);
  endtask

  int   n_push;
  int   n_addr;
  int   n_rsp;
  logic acc_prev;

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'd0;
    bus.cmd_wdata = 32'd0;
    bus.cmd_size  = 3'd0;
    bus.HREADY    = 1'b1;
    bus.HRESP     = 1'b0;
    bus.HRDATA    = 32'd0;

    // Per cycle: inputs present that cycle, outputs expected in that cycle
    // Single write, zero wait
    vin(1, 1, 32'h1000, 32'hDEADBEEF, 2, 1, 0, 0); vout(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(0); vout(1, 2, 32'h1000, 1, 2, 0, 0, 0, 0, 0);
    nop(0); vout(1, 0, 32'h1000, 1, 2, 32'hDEADBEEF, 0, 0, 0, 0);
    nop(0); vout(1, 0, 32'h1000, 1, 2, 32'hDEADBEEF, 1, 1, 0, 0);
    // Four back-to-back reads
    vin(1, 0, 32'h0, 0, 2, 1, 0, 0); vout(1, 0, 32'h1000, 1, 2, 32'hDEADBEEF, 0, 0, 0, 0);
    vin(1, 0, 32'h4, 0, 2, 1, 0, 0); vout(1, 2, 32'h0, 0, 2, 32'hDEADBEEF, 0, 0, 0, 0);
    vin(1, 0, 32'h8, 0, 2, 1, 0, 32'hA0); vout(1, 2, 32'h4, 0, 2, 32'hDEADBEEF, 0, 0, 0, 0);
    vin(1, 0, 32'hC, 0, 2, 1, 0, 32'hA4); vout(1, 2, 32'h8, 0, 2, 32'hDEADBEEF, 1, 0, 0, 32'hA0);
    nop(32'hA8); vout(1, 2, 32'hC, 0, 2, 32'hDEADBEEF, 1, 0, 0, 32'hA4);
    nop(32'hAC); vout(1, 0, 32'hC, 0, 2, 32'hDEADBEEF, 1, 0, 0, 32'hA8);
    nop(0); vout(1, 0, 32'hC, 0, 2, 32'hDEADBEEF, 1, 0, 0, 32'hAC);
    nop(0); vout(1, 0, 32'hC, 0, 2, 32'hDEADBEEF, 0, 0, 0, 0);
    // Read with three wait states, write queued behind it
    vin(1, 0, 32'h20, 0, 2, 1, 0, 0); vout(1, 0, 32'hC, 0, 2, 32'hDEADBEEF, 0, 0, 0, 0);
    vin(1, 1, 32'h24, 32'h11223344, 2, 1, 0, 0);
    vout(1, 2, 32'h20, 0, 2, 32'hDEADBEEF, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      vin(0, 0, 0, 0, 0, 0, 0, 0); vout(1, 2, 32'h24, 1, 2, 32'hDEADBEEF, 0, 0, 0, 0);
    end
    nop(32'hB20); vout(1, 2, 32'h24, 1, 2, 32'hDEADBEEF, 0, 0, 0, 0);
    nop(0); vout(1, 0, 32'h24, 1, 2, 32'h11223344, 1, 0, 0, 32'hB20);
    nop(0); vout(1, 0, 32'h24, 1, 2, 32'h11223344, 1, 1, 0, 0);
    // Two-cycle ERROR on the first of two writes
    vin(1, 1, 32'h40, 32'hAAAA0001, 2, 1, 0, 0);
    vout(1, 0, 32'h24, 1, 2, 32'h11223344, 0, 0, 0, 0);
    vin(1, 1, 32'h44, 32'hBBBB0002, 2, 1, 0, 0);
    vout(1, 2, 32'h40, 1, 2, 32'h11223344, 0, 0, 0, 0);
    vin(0, 0, 0, 0, 0, 0, 1, 0); vout(1, 0, 32'h40, 1, 2, 32'hAAAA0001, 0, 0, 0, 0);
    vin(0, 0, 0, 0, 0, 1, 1, 0); vout(1, 0, 32'h40, 1, 2, 32'hAAAA0001, 0, 0, 0, 0);
    nop(0); vout(1, 2, 32'h44, 1, 2, 32'hAAAA0001, 1, 1, 1, 0);
    nop(0); vout(1, 0, 32'h44, 1, 2, 32'hBBBB0002, 0, 0, 0, 0);
    nop(0); vout(1, 0, 32'h44, 1, 2, 32'hBBBB0002, 1, 1, 0, 0);
    // Misaligned word read: no transfer, error response
    vin(1, 0, 32'h1002, 0, 2, 1, 0, 0); vout(1, 0, 32'h44, 1, 2, 32'hBBBB0002, 0, 0, 0, 0);
    nop(0); vout(1, 0, 32'h44, 1, 2, 32'hBBBB0002, 0, 0, 0, 0);
    nop(0); vout(1, 0, 32'h44, 1, 2, 32'hBBBB0002, 1, 0, 1, 0);
    // Oversized write: no transfer, error response
    vin(1, 1, 32'h0, 32'h77, 3, 1, 0, 0); vout(1, 0, 32'h44, 1, 2, 32'hBBBB0002, 0, 0, 0, 0);
    nop(0); vout(1, 0, 32'h44, 1, 2, 32'hBBBB0002, 0, 0, 0, 0);
    nop(0); vout(1, 0, 32'h44, 1, 2, 32'hBBBB0002, 1, 1, 1, 0);
    // Aligned halfword read at the same address is legal
    vin(1, 0, 32'h1002, 0, 1, 1, 0, 0); vout(1, 0, 32'h44, 1, 2, 32'hBBBB0002, 0, 0, 0, 0);
    nop(0); vout(1, 2, 32'h1002, 0, 1, 32'hBBBB0002, 0, 0, 0, 0);
    nop(32'hCAFE); vout(1, 0, 32'h1002, 0, 1, 32'hBBBB0002, 0, 0, 0, 0);
    nop(0); vout(1, 0, 32'h1002, 0, 1, 32'hBBBB0002, 1, 0, 0, 32'hCAFE);

    repeat (2) @(negedge clk);
    #1;
    check_reset(0);
    rst_n = 1'b1;

    for (int i = 0; i < int'(vecs.size()); i++) begin
      vec_t v;
      v = vecs[i];
      @(negedge clk);
      bus.cmd_valid = v.cv;
      bus.cmd_write = v.cw;
      bus.cmd_addr  = v.caddr;
      bus.cmd_wdata = v.cwdata;
      bus.cmd_size  = v.csize;
      bus.HREADY    = v.hready;
      bus.HRESP     = v.hresp;
      bus.HRDATA    = v.hrdata;
      #1;
      check("cmd_ready", i, 32'(bus.cmd_ready), 32'(v.e_ready));
      check("HTRANS", i, 32'(bus.HTRANS), 32'(v.e_htrans));
      check("HADDR", i, bus.HADDR, v.e_haddr);
      check("HWRITE", i, 32'(bus.HWRITE), 32'(v.e_hwrite));
      check("HSIZE", i, 32'(bus.HSIZE), 32'(v.e_hsize));
      check("HWDATA", i, bus.HWDATA, v.e_hwdata);
      check("rsp_valid", i, 32'(bus.rsp_valid), 32'(v.e_rv));
      if (v.e_rv) begin
        check("rsp_write", i, 32'(bus.rsp_write), 32'(v.e_rw));
        check("rsp_err", i, 32'(bus.rsp_err), 32'(v.e_re));
        check("rsp_rdata", i, bus.rsp_rdata, v.e_rdata);
      end
    end

    // Five writes pushed against a stalled bus: FIFO fills at four, none lost
    n_push   = 0;
    n_addr   = 0;
    n_rsp    = 0;
    acc_prev = 1'b0;
    for (int cyc = 0; cyc < 26; cyc++) begin
      @(negedge clk);
      bus.HREADY    = (cyc >= 5);
      bus.HRESP     = 1'b0;
      bus.HRDATA    = 32'd0;
      bus.cmd_valid = (n_push < 5);
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 32'h100 + 32'(4 * n_push);
      bus.cmd_wdata = 32'hC0 + 32'(n_push);
      bus.cmd_size  = 3'd2;
      #1;
      if (cyc < 4) begin
        check("full_ready", cyc, 32'(bus.cmd_ready), 32'd1);
      end else if (cyc < 6) begin
        check("full_ready", cyc, 32'(bus.cmd_ready), 32'd0);
      end else if (cyc == 6) begin
        check("full_ready", cyc, 32'(bus.cmd_ready), 32'd1);
      end
      if (acc_prev) begin
        check("seq_hwdata", n_addr - 1, bus.HWDATA, 32'hC0 + 32'(n_addr - 1));
      end
      acc_prev = 1'b0;
      if (bus.HTRANS == 2'b10 && bus.HREADY) begin
        check("seq_haddr", n_addr, bus.HADDR, 32'h100 + 32'(4 * n_addr));
        n_addr++;
        acc_prev = 1'b1;
      end
      if (bus.rsp_valid) begin
        check("seq_rsp_err", n_rsp, 32'(bus.rsp_err), 32'd0);
        check("seq_rsp_write", n_rsp, 32'(bus.rsp_write), 32'd1);
        n_rsp++;
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        n_push++;
      end
    end
    check("seq_pushed", 0, n_push, 32'd5);
    check("seq_issued", 0, n_addr, 32'd5);
    check("seq_responses", 0, n_rsp, 32'd5);

    // Reset while one write is in data phase and the next in address phase
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h200;
    bus.cmd_wdata = 32'h99;
    @(negedge clk);
    bus.cmd_addr  = 32'h204;
    bus.cmd_wdata = 32'h98;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    #1;
    check("mid_htrans", 0, 32'(bus.HTRANS), 32'd2);
    check("mid_hwdata", 0, bus.HWDATA, 32'h99);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset(1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check("post_rst_rsp_valid", k, 32'(bus.rsp_valid), 32'd0);
      check("post_rst_htrans", k, 32'(bus.HTRANS), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_lite_master_driver.md
AHB_LITE_MASTER_DRIVER -- requirements
Module: ahb_lite_master_driver

Interface
REQ-001 SHALL have parameter ADDR_W, 32, HADDR and cmd_addr width.
REQ-002 SHALL have parameter DATA_W, 32, HWDATA, HRDATA, cmd_wdata and rsp_rdata width.
REQ-003 SHALL have parameter CMD_DEPTH, 4, command FIFO entries (power of 2, >=2).
REQ-004 SHALL have port HCLK  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port HRESETn  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_write in 1, cmd_addr in ADDR_W, cmd_wdata in DATA_W, cmd_size in 3: command push (valid/ready).
REQ-007 SHALL have ports rsp_valid out 1, rsp_write out 1, rsp_err out 1, rsp_rdata out DATA_W: completion report, no backpressure.
REQ-008 SHALL have AHB master outputs HADDR ADDR_W, HWRITE 1, HSIZE 3, HBURST 3, HPROT 4, HTRANS 2, HMASTLOCK 1, HWDATA DATA_W.
REQ-009 SHALL have AHB inputs HRDATA DATA_W, HREADY 1, HRESP 1 (0 OKAY, 1 ERROR).

Function
REQ-010 Command accepted when cmd_valid && cmd_ready; cmd_ready = FIFO not full.
REQ-011 Accepted commands SHALL execute strictly in order as single transfers: HBURST=SINGLE, HTRANS only IDLE(00) or NONSEQ(10), HMASTLOCK=0, HPROT=4'b0011.
REQ-012 Misaligned command (cmd_addr not a multiple of 2**cmd_size) or cmd_size > log2(DATA_W/8) SHALL issue no bus transfer and SHALL produce rsp_valid with rsp_err=1, in order with other responses.
REQ-013 Address phase: HTRANS=NONSEQ with HADDR/HWRITE/HSIZE from FIFO head whenever FIFO non-empty and not in ERR; otherwise HTRANS=IDLE, other address outputs hold last value.
REQ-014 Address phase SHALL be accepted on a rising edge with HREADY=1; head popped at that edge; outputs SHALL hold stable while HREADY=0.
REQ-015 Pipelining: next NONSEQ SHALL be presented in the same cycle as the previous transfer's data phase (zero-bubble back-to-back).
REQ-016 HWDATA SHALL carry the write data of the transfer in data phase, stable until HREADY=1; for reads HWDATA holds its previous value.
REQ-017 Data phase completes at edge with HREADY=1; next cycle rsp_valid=1 for exactly one cycle with rsp_write, rsp_err=HRESP, rsp_rdata=HRDATA sampled at that edge (0 for writes).
REQ-018 State machine: IDLE (no transfer outstanding), ADDR (address pending, no data phase), ADDR_DATA (address pending + data phase), DATA (data phase only), ERR.
REQ-019 Transitions: IDLE->ADDR on FIFO non-empty; ADDR->ADDR_DATA/DATA on HREADY=1 (next entry present/absent); ADDR_DATA stays while HREADY=0, else on HREADY=1 ->ADDR_DATA/DATA; DATA->IDLE or ADDR on HREADY=1.
REQ-020 Error: HRESP=1 with HREADY=0 in a data phase -> ERR; HTRANS SHALL be IDLE that cycle, pending address not popped (retried after ERR); ERR exits on HREADY=1 reporting rsp_err=1.
REQ-021 Latency: command into empty FIFO -> NONSEQ on bus the cycle after acceptance; zero-wait transfer -> rsp_valid 3 cycles after acceptance.
REQ-022 Simultaneous push and pop when full SHALL be refused (cmd_ready=0); push and pop when non-full both take effect.

Reset
REQ-023 HRESETn=0 SHALL asynchronously force: state IDLE, FIFO empty, cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_write=0, rsp_rdata=0, HTRANS=00, HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HPROT=4'b0011, HMASTLOCK=0, HWDATA=0.
REQ-024 Reset mid-transfer SHALL discard all queued and outstanding commands with no response issued.

Verification
REQ-025 Write 0x1000 data 0xDEADBEEF size 2, HREADY=1 -> NONSEQ cycle 1, HWDATA=0xDEADBEEF cycle 2, rsp_valid write err=0 cycle 3.
REQ-026 Four back-to-back reads 0x0,0x4,0x8,0xC, zero wait -> four consecutive NONSEQ cycles, four consecutive rsp_valid pulses, rdata in order.
REQ-027 Read 0x20 with HREADY=0 for 3 cycles -> HADDR/HTRANS of following command and HWDATA held stable; single rsp_valid after HREADY=1.
REQ-028 Two-cycle ERROR on first of two writes -> HTRANS=IDLE in first error cycle, second write re-presented after, responses err=1 then err=0.
REQ-029 Push 5 commands while HREADY=0 with CMD_DEPTH=4 -> cmd_ready=0 after 4th accepted entry (head already in address phase counts); none lost.
REQ-030 Command addr 0x1002 size 2 -> no NONSEQ, rsp_valid err=1; HRESETn pulse mid-burst -> all outputs at REQ-023 values immediately.
